// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with BOOT/RUN/HALT sequencing and a PC history delay line.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned redirect targets trap to the exception vector.
module pc_sequencer #(
   parameter int          WIDTH        = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h00400000,
   parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
   parameter int          STEP         = 4,
   parameter int          HIST_DEPTH   = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        pause,
   input  logic                        redirect,
   input  logic [WIDTH-1:0]            redirect_target,
   input  logic                        exception,
   input  logic                        halt_req,
   input  logic                        resume,
   output logic [WIDTH-1:0]            pc_output,
   output logic                        pc_valid,
   output logic                        halted,
   output logic [HIST_DEPTH*WIDTH-1:0] pc_hist,
   output logic                        misalign
);

   localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
   localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] pc_next;
   logic             load;
   logic             misalign_next;
   logic [WIDTH-1:0] hist [HIST_DEPTH];

   // pc_valid/halted are derived from next_state so they change on the same edge as the state
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= BOOT;
         pc_output <= RST_PC;
         pc_valid  <= 1'b0;
         halted    <= 1'b0;
         misalign  <= 1'b0;
         for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
      end else begin
         state    <= next_state;
         pc_valid <= (next_state == RUN);
         halted   <= (next_state == HALT);
         misalign <= misalign_next;
         if (load) begin
            pc_output <= pc_next;
            hist[0]   <= pc_output;
            for (int k = 1; k < HIST_DEPTH; k++) hist[k] <= hist[k-1];
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         BOOT: next_state = RUN;
         RUN:  if (!exception && !redirect && halt_req) next_state = HALT;
         HALT: if (exception || resume) next_state = RUN;
         default: next_state = BOOT;
      endcase
   end

   // A redirect wins over pause, so only step advance is gated by pause/halt_req
   always_comb begin
      pc_next       = pc_output;
      load          = 1'b0;
      misalign_next = 1'b0;
      case (state)
         RUN: begin
            if (exception) begin
               pc_next = EXC_PC;
               load    = 1'b1;
            end else if (redirect) begin
               load = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
               if (redirect_target[1:0] != 2'b00) begin
                  pc_next       = EXC_PC;
                  misalign_next = 1'b1;
               end else begin
                  pc_next = redirect_target;
               end
`else
               pc_next = redirect_target;
`endif
            end else if (!halt_req && !pause && enable) begin
               pc_next = pc_output + STEP_W;
               load    = 1'b1;
            end
         end
         HALT: begin
            if (exception) begin
               pc_next = EXC_PC;
               load    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
      assign pc_hist[g*WIDTH +: WIDTH] = hist[g];
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues the expected outputs for each
// driven cycle, which are popped and compared one clock later.
module tb_pc_sequencer;

   localparam int          WIDTH = 32;
   localparam int          HD    = 3;
   localparam logic [31:0] RV    = 32'h00400000;
   localparam logic [31:0] EV    = 32'h00400004;

   logic             clock = 1'b0;
   logic             reset, enable, pause, redirect, exception, halt_req, resume;
   logic [WIDTH-1:0] redirect_target;
   logic [WIDTH-1:0] pc_output;
   logic             pc_valid, halted, misalign;
   logic [HD*WIDTH-1:0] pc_hist;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      logic [95:0] hist;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   // Model state: 0=BOOT, 1=RUN, 2=HALT
   int          m_state;
   logic [31:0] m_pc;
   logic [31:0] m_hist [HD];
   logic        m_mis;

   pc_sequencer dut (
      .clock(clock), .reset(reset), .enable(enable), .pause(pause),
      .redirect(redirect), .redirect_target(redirect_target),
      .exception(exception), .halt_req(halt_req), .resume(resume),
      .pc_output(pc_output), .pc_valid(pc_valid), .halted(halted),
      .pc_hist(pc_hist), .misalign(misalign)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic modelLoad(input logic [31:0] v);
      for (int k = HD-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_pc;
      m_pc      = v;
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic ps, input logic rd,
                                input logic [31:0] tgt, input logic ex, input logic hr,
                                input logic rs);
      exp_t e;
      exp_t got;
      reset = rst; enable = en; pause = ps; redirect = rd; redirect_target = tgt;
      exception = ex; halt_req = hr; resume = rs;
      m_mis = 1'b0;
      if (rst) begin
         m_state = 0;
         m_pc    = RV;
         for (int k = 0; k < HD; k++) m_hist[k] = '0;
      end else begin
         case (m_state)
            0: m_state = 1;
            1: begin
               if (ex) modelLoad(EV);
               else if (rd) begin
`ifdef PC_ALIGN_CHECK_EN
                  if (tgt[1:0] != 2'b00) begin
                     modelLoad(EV);
                     m_mis = 1'b1;
                  end else modelLoad(tgt);
`else
                  modelLoad(tgt);
`endif
               end else if (hr) m_state = 2;
               else if (ps) ;
               else if (en) modelLoad(m_pc + 32'd4);
            end
            default: begin
               if (ex) begin
                  modelLoad(EV);
                  m_state = 1;
               end else if (rs) m_state = 1;
            end
         endcase
      end
      e.pc     = m_pc;
      e.valid  = (m_state == 1);
      e.halted = (m_state == 2);
      e.hist   = {m_hist[2], m_hist[1], m_hist[0]};
      e.mis    = m_mis;
      sb.push_back(e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      checkOutput("pc",       96'(pc_output), 96'(got.pc));
      checkOutput("pc_valid", 96'(pc_valid),  96'(got.valid));
      checkOutput("halted",   96'(halted),    96'(got.halted));
      checkOutput("pc_hist",  pc_hist,        got.hist);
      checkOutput("misalign", 96'(misalign),  96'(got.mis));
   endtask

   // Shorthands for the common stimulus shapes
   task automatic stepEn();
      applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic jumpTo(input logic [31:0] t);
      applyStimulus(0, 0, 0, 1, t, 0, 0, 0);
   endtask

   initial begin
      // Reset and boot sequence
      applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
      checkOutput("tp_reset_pc", 96'(pc_output), 96'(32'h00400000));
      checkOutput("tp_reset_valid", 96'(pc_valid), 96'(1'b0));
      stepEn();
      checkOutput("tp_boot_pc", 96'(pc_output), 96'(32'h00400000));
      checkOutput("tp_boot_valid", 96'(pc_valid), 96'(1'b1));
      stepEn();
      checkOutput("tp_step1", 96'(pc_output), 96'(32'h00400004));
      stepEn();
      checkOutput("tp_step2", 96'(pc_output), 96'(32'h00400008));
      checkOutput("tp_hist0", 96'(pc_hist[31:0]), 96'(32'h00400004));
      stepEn();
      stepEn();

      // Pause with redirect on the second paused cycle
      applyStimulus(0, 1, 1, 0, 32'h0, 0, 0, 0);
      checkOutput("tp_pause_hold", 96'(pc_output), 96'(32'h00400010));
      applyStimulus(0, 1, 1, 1, 32'h00401000, 0, 0, 0);
      checkOutput("tp_pause_redir", 96'(pc_output), 96'(32'h00401000));
      checkOutput("tp_pause_hist0", 96'(pc_hist[31:0]), 96'(32'h00400010));
      applyStimulus(0, 1, 1, 0, 32'h0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0);

      // Exception beats redirect
      applyStimulus(0, 1, 0, 1, 32'h00402000, 1, 0, 0);
      checkOutput("tp_exc_over_redir", 96'(pc_output), 96'(32'h00400004));

      // Halt, ignore stimulus while halted, resume
      jumpTo(32'h00400020);
      applyStimulus(0, 1, 0, 0, 32'h0, 0, 1, 0);
      checkOutput("tp_halted", 96'(halted), 96'(1'b1));
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, (i == 1), (i == 2), 32'h00403000, 0, 0, 0);
      checkOutput("tp_halt_frozen", 96'(pc_output), 96'(32'h00400020));
      applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 1);
      checkOutput("tp_resume_pc", 96'(pc_output), 96'(32'h00400020));
      stepEn();
      checkOutput("tp_resume_step", 96'(pc_output), 96'(32'h00400024));

      // Exception wakes from HALT, also when resume arrives together
      applyStimulus(0, 1, 0, 0, 32'h0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 32'h0, 1, 0, 0);
      checkOutput("tp_halt_exc", 96'(pc_output), 96'(32'h00400004));
      stepEn();
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 1, 0, 1);
      checkOutput("tp_halt_exc_resume", 96'(pc_output), 96'(32'h00400004));

      // Redirect overrides halt_req; redirect to the same pc still shifts history
      applyStimulus(0, 0, 0, 1, 32'h00400040, 0, 1, 0);
      jumpTo(32'h00400040);
      checkOutput("tp_same_redir_hist", 96'(pc_hist[31:0]), 96'(32'h00400040));

      // Wrap at the top of the address space
      jumpTo(32'hFFFFFFFC);
      stepEn();
      checkOutput("tp_wrap", 96'(pc_output), 96'(32'h00000000));

      // Mid-run reset
      jumpTo(32'h00400100);
      applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0);
      checkOutput("tp_midreset_pc", 96'(pc_output), 96'(32'h00400000));
      checkOutput("tp_midreset_hist", pc_hist, 96'h0);
      stepEn();

      // Misaligned redirect target
      jumpTo(32'h00400102);
`ifdef PC_ALIGN_CHECK_EN
      checkOutput("tp_misalign_pc", 96'(pc_output), 96'(32'h00400004));
      checkOutput("tp_misalign_pulse", 96'(misalign), 96'(1'b1));
`else
      checkOutput("tp_misalign_pc", 96'(pc_output), 96'(32'h00400102));
      checkOutput("tp_misalign_pulse", 96'(misalign), 96'(1'b0));
`endif
      stepEn();
      checkOutput("tp_misalign_clear", 96'(misalign), 96'(1'b0));
      applyStimulus(0, 0, 0, 1, 32'h00400203, 1, 0, 0);
      checkOutput("tp_misalign_exc", 96'(misalign), 96'(1'b0));

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(3) != 0) t[1:0] = 2'b00;
         applyStimulus(($urandom_range(40) == 0), 1'($urandom_range(1)),
                       ($urandom_range(3) == 0), ($urandom_range(5) == 0), t,
                       ($urandom_range(9) == 0), ($urandom_range(7) == 0),
                       ($urandom_range(3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
